mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Upstream driver for the 8-to-1 multiplexer. Accepts an 8-bit word over a valid/ready load handshake and holds it on `input_lines`. Then steps `select_lines` through all eight indices, holding each for a programmable dwell time. Each settled index is presented to a downstream consumer with its own valid/ready handshake, so the consumer can sample the mux `out` at that point. One word is scanned at a time; a new word is accepted only after the current scan completes.

## Interface
- `DWELL`, default 20: minimum cycles each select index is held before it is offered downstream; legal range 1..255.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `load_valid` in 1: upstream offers `load_data`.
- `load_ready` out 1: block can accept a word.
- `load_data` in 8: word to scan.
- `input_lines` out 8: captured word, wired to the mux input lines.
- `select_lines` out 3: current index, wired to the mux select lines.
- `step_valid` out 1: current index has been held for `DWELL` cycles and the mux output is settled.
- `scan_ready` in 1: consumer accepts the current step.
- `scan_last` out 1: current step is the final index of the word.
- `busy` out 1: scan in progress.

## Operation
- Two states, `IDLE` and `SCAN`.
- **Outputs by state:**
  - `load_ready = (state==IDLE) && !reset`
  - `busy = (state==SCAN)`
- **IDLE to SCAN:** on the edge where `load_valid && load_ready`:
  - capture `load_data` into `input_lines`;
  - set `select_lines` to the first index (0);
  - clear the dwell counter;
  - enter `SCAN`.
- **Dwell counter (in SCAN):**
  - The counter is 8 bits and counts cycles at the current index: 0 on the first cycle, then incrementing.
  - It saturates at `DWELL-1`.
- **step_valid:**
  - `step_valid = (state==SCAN) && (dwell_cnt == DWELL-1)`.
  - Once high, it stays high, with `select_lines` unchanged, until `scan_ready`.
- **Step handshake:** on an edge where `step_valid && scan_ready`:
  - If the index is not the last: advance to the next index and clear the dwell counter.
  - If the index is the last: go to `IDLE`.
- **scan_last:** `scan_last = step_valid && (select_lines == last index)`; the last index is 7.
- **On return to IDLE:**
  - `select_lines` returns to the first index.
  - `input_lines` retains the scanned word until the next load.
- **Ignored inputs:**
  - `load_valid` in `SCAN` is ignored (`load_ready` = 0).
  - `scan_ready` without `step_valid` is ignored and causes no advance.

## Timing
- **Reset values** (the edge with `reset` high):
  - `input_lines` = 8'h00, `select_lines` = 3'b000, state `IDLE`.
  - `step_valid`, `scan_last`, `busy` = 0.
  - `load_ready` = 0 while `reset` is high and 1 on the first cycle after release.
- **Load latency:** `input_lines` and `select_lines` update on the load-handshake edge. `busy` rises in the following cycle.
- **Step timing:** `step_valid` is first high in the `DWELL`-th cycle at an index (cycle index `DWELL-1`).
  - With `DWELL`=1, `step_valid` is high from the first cycle at each index.
- **Throughput with `scan_ready` held high:**
  - One index per `DWELL` cycles; a full word takes 8×`DWELL` cycles in `SCAN`.
  - At least one `IDLE` cycle separates words: the next load handshake comes at the earliest one cycle after the final step handshake.
- **Consumer stall:** a stalled consumer extends the current index indefinitely. The dwell counter stays saturated, and no index is skipped or repeated.
- **Reset mid-scan:** the scan aborts. No further `step_valid` is issued after the reset edge, and all outputs take their reset values.
- **Simultaneous `reset` and a handshake:** reset wins; the handshake is discarded.

## Configuration
- Macro `MUX_SCAN_MSB_FIRST_EN`.
- **Undefined:** scan order is 0→7; first index is 0, last index is 7.
- **Defined:**
  - Scan order is 7→0; first index is 7, last index is 0.
  - `select_lines` loads 3'b111 on the load handshake and returns to 3'b111 in `IDLE`.
  - Reset value of `select_lines` stays 3'b000.
- The handshake, dwell and `scan_last` rules are identical in both builds.

## Test plan
- **Basic scan:** `DWELL`=20, load 8'b01110001, `scan_ready`=1.
  - `select_lines` steps 0..7, changing every 20 cycles.
  - The mux `out` sampled on each step handshake reads 1,0,0,0,1,1,1,0.
  - `scan_last` is high only at index 7.
  - `busy` falls after 160 cycles.
- **Minimum dwell:** `DWELL`=1, load 8'hA5, `scan_ready`=1.
  - 8 consecutive step handshakes on 8 consecutive cycles, indices 0..7.
  - `load_ready` = 1 in the next cycle.
- **Backpressure:** `DWELL`=2, hold `scan_ready`=0 for 10 cycles at index 3.
  - `select_lines` stays 3 and `step_valid` stays 1 throughout.
  - Index 4 appears on the edge after `scan_ready` rises.
- **Load during scan:** assert `load_valid` with 8'hFF mid-scan of 8'h0F.
  - `load_ready` = 0 and `input_lines` stays 8'h0F.
  - 8'hFF is accepted in the first `IDLE` cycle.
- **Reset mid-scan:** assert `reset` at index 5.
  - Next cycle: `input_lines` = 0, `select_lines` = 0, `step_valid` = 0, `busy` = 0.
  - `load_ready` = 1 after release.
- **MSB-first build:** build with `MUX_SCAN_MSB_FIRST_EN`, load 8'b01110001.
  - Indices run 7..0 and sampled bits read 0,1,1,1,0,0,0,1.
  - `scan_last` is asserted at index 0.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Feeds an 8-to-1 mux: latches a word, then walks select_lines over all eight
// indices with a programmable dwell. Define MUX_SCAN_MSB_FIRST_EN to scan 7->0.
module mux_scan_sequencer #(
   parameter int unsigned DWELL = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_data,
   output logic [7:0] input_lines,
   output logic [2:0] select_lines,
   output logic       step_valid,
   input  logic       scan_ready,
   output logic       scan_last,
   output logic       busy
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

`ifdef MUX_SCAN_MSB_FIRST_EN
   localparam logic [2:0] FIRST_IDX = 3'd7;
   localparam logic [2:0] LAST_IDX  = 3'd0;
`else
   localparam logic [2:0] FIRST_IDX = 3'd0;
   localparam logic [2:0] LAST_IDX  = 3'd7;
`endif

   state_t     state_q, state_d;
   logic [7:0] word_q,  word_d;
   logic [2:0] sel_q,   sel_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [2:0] sel_next;
   logic       step_fire;

`ifdef MUX_SCAN_MSB_FIRST_EN
   assign sel_next = sel_q - 3'd1;
`else
   assign sel_next = sel_q + 3'd1;
`endif

   assign load_ready   = (state_q == IDLE) && !reset;
   assign busy         = (state_q == SCAN);
   assign step_valid   = busy && (cnt_q == DWELL_M1);
   assign scan_last    = step_valid && (sel_q == LAST_IDX);
   assign input_lines  = word_q;
   assign select_lines = sel_q;
   assign step_fire    = step_valid && scan_ready;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               word_d  = load_data;
               sel_d   = FIRST_IDX;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (step_fire) begin
               if (sel_q == LAST_IDX) begin
                  state_d = IDLE;
                  sel_d   = FIRST_IDX;
               end else begin
                  sel_d = sel_next;
                  cnt_d = '0;
               end
            end else if (cnt_q != DWELL_M1) begin
               // saturating hold keeps step_valid asserted through a stall
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: three instances (DWELL 20, 1, 2)
// driven from a scan-vector table plus hand-written corner-case sequences.
module tb_mux_scan_sequencer;

   localparam int DW [3] = '{20, 1, 2};

   logic       clk;
   logic       rst  [3];
   logic       lv   [3];
   logic       lr   [3];
   logic [7:0] ld   [3];
   logic [7:0] li   [3];
   logic [2:0] sl   [3];
   logic       sv   [3];
   logic       sr   [3];
   logic       slst [3];
   logic       bz   [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic [7:0] seq;   // bit k = mux output expected at the k-th step
   } vec_t;

   vec_t vecs [4];

   mux_scan_sequencer #(.DWELL(20)) u_d20 (
      .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_ready(lr[0]),
      .load_data(ld[0]), .input_lines(li[0]), .select_lines(sl[0]),
      .step_valid(sv[0]), .scan_ready(sr[0]), .scan_last(slst[0]), .busy(bz[0]));

   mux_scan_sequencer #(.DWELL(1)) u_d1 (
      .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_ready(lr[1]),
      .load_data(ld[1]), .input_lines(li[1]), .select_lines(sl[1]),
      .step_valid(sv[1]), .scan_ready(sr[1]), .scan_last(slst[1]), .busy(bz[1]));

   mux_scan_sequencer #(.DWELL(2)) u_d2 (
      .clk(clk), .reset(rst[2]), .load_valid(lv[2]), .load_ready(lr[2]),
      .load_data(ld[2]), .input_lines(li[2]), .select_lines(sl[2]),
      .step_valid(sv[2]), .scan_ready(sr[2]), .scan_last(slst[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] exp_idx(input int k);
`ifdef MUX_SCAN_MSB_FIRST_EN
      return 3'(7 - k);
`else
      return 3'(k);
`endif
   endfunction

   function automatic logic mux(input int i);
      return li[i][sl[i]];
   endfunction

   task automatic wait_idle(input int i);
      sr[i] = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if (!bz[i]) break;
         step();
      end
      chk("idle_timeout", 32'(bz[i]), 32'd0);
   endtask

   task automatic run_scan(input int i, input logic [7:0] d, input logic [7:0] seq);
      int k, t, cyc;
      chk("load_ready_idle", 32'(lr[i]), 32'd1);
      lv[i] = 1'b1;
      ld[i] = d;
      sr[i] = 1'b1;
      step();
      lv[i] = 1'b0;
      chk("load_capture", 32'(li[i]), 32'(d));
      chk("first_index", 32'(sl[i]), 32'(exp_idx(0)));
      chk("busy_rise", 32'(bz[i]), 32'd1);
      k = 0; t = 0; cyc = 0;
      while (k < 8 && cyc < 2200) begin
         cyc++;
         t++;
         if (sv[i]) begin
            chk("step_index", 32'(sl[i]), 32'(exp_idx(k)));
            chk("dwell_len", 32'(t), 32'(DW[i]));
            chk("mux_out", 32'(mux(i)), 32'(seq[k]));
            chk("scan_last", 32'(slst[i]), 32'(k == 7));
            k++;
            t = 0;
         end else begin
            chk("scan_last_low", 32'(slst[i]), 32'd0);
         end
         step();
      end
      chk("steps_done", 32'(k), 32'd8);
      chk("scan_cycles", 32'(cyc), 32'(8 * DW[i]));
      chk("busy_fall", 32'(bz[i]), 32'd0);
      chk("load_ready_after", 32'(lr[i]), 32'd1);
      chk("select_home", 32'(sl[i]), 32'(exp_idx(0)));
      chk("word_held", 32'(li[i]), 32'(d));
   endtask

   initial begin
`ifdef MUX_SCAN_MSB_FIRST_EN
      vecs[0] = '{inst: 0, data: 8'b01110001, seq: 8'b10001110};
      vecs[1] = '{inst: 1, data: 8'hA5,       seq: 8'hA5};
      vecs[2] = '{inst: 2, data: 8'h2D,       seq: 8'hB4};
      vecs[3] = '{inst: 1, data: 8'hC4,       seq: 8'h23};
`else
      vecs[0] = '{inst: 0, data: 8'b01110001, seq: 8'b01110001};
      vecs[1] = '{inst: 1, data: 8'hA5,       seq: 8'hA5};
      vecs[2] = '{inst: 2, data: 8'h2D,       seq: 8'h2D};
      vecs[3] = '{inst: 1, data: 8'hC4,       seq: 8'hC4};
`endif
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; lv[i] = 1'b0; ld[i] = '0; sr[i] = 1'b0;
      end
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         chk("rst_input_lines", 32'(li[i]), 32'd0);
         chk("rst_select", 32'(sl[i]), 32'd0);
         chk("rst_step_valid", 32'(sv[i]), 32'd0);
         chk("rst_scan_last", 32'(slst[i]), 32'd0);
         chk("rst_busy", 32'(bz[i]), 32'd0);
         chk("rst_load_ready", 32'(lr[i]), 32'd0);
         rst[i] = 1'b0;
      end
      #1;
      for (int i = 0; i < 3; i++) chk("release_load_ready", 32'(lr[i]), 32'd1);
      step();

      for (int v = 0; v < 4; v++) begin
         run_scan(vecs[v].inst, vecs[v].data, vecs[v].seq);
         step();
      end

      // consumer stall at the fourth index, DWELL=2
      lv[2] = 1'b1; ld[2] = 8'h3C; sr[2] = 1'b1;
      step();
      lv[2] = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (sl[2] == exp_idx(3)) break;
         step();
      end
      chk("reach_idx3", 32'(sl[2]), 32'(exp_idx(3)));
      sr[2] = 1'b0;
      step();
      for (int j = 0; j < 10; j++) begin
         chk("stall_index", 32'(sl[2]), 32'(exp_idx(3)));
         chk("stall_valid", 32'(sv[2]), 32'd1);
         step();
      end
      sr[2] = 1'b1;
      step();
      chk("resume_index", 32'(sl[2]), 32'(exp_idx(4)));
      chk("resume_valid_low", 32'(sv[2]), 32'd0);
      wait_idle(2);
      step();

      // load offered while scanning
      lv[2] = 1'b1; ld[2] = 8'h0F; sr[2] = 1'b1;
      step();
      lv[2] = 1'b0;
      step();
      lv[2] = 1'b1; ld[2] = 8'hFF;
      for (int n = 0; n < 40; n++) begin
         if (!bz[2]) break;
         chk("scan_load_ready", 32'(lr[2]), 32'd0);
         chk("scan_word_kept", 32'(li[2]), 32'h0F);
         step();
      end
      chk("first_idle_ready", 32'(lr[2]), 32'd1);
      chk("first_idle_word", 32'(li[2]), 32'h0F);
      step();
      lv[2] = 1'b0;
      chk("second_word", 32'(li[2]), 32'hFF);
      chk("second_busy", 32'(bz[2]), 32'd1);
      chk("second_first_idx", 32'(sl[2]), 32'(exp_idx(0)));
      wait_idle(2);
      step();

      // reset in the middle of a scan, with a load offered on the reset edge
      lv[0] = 1'b1; ld[0] = 8'hC3; sr[0] = 1'b1;
      step();
      lv[0] = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (sl[0] == exp_idx(5)) break;
         step();
      end
      chk("reach_idx5", 32'(sl[0]), 32'(exp_idx(5)));
      rst[0] = 1'b1; lv[0] = 1'b1; ld[0] = 8'h55;
      step();
      chk("midrst_input_lines", 32'(li[0]), 32'd0);
      chk("midrst_select", 32'(sl[0]), 32'd0);
      chk("midrst_step_valid", 32'(sv[0]), 32'd0);
      chk("midrst_busy", 32'(bz[0]), 32'd0);
      chk("midrst_scan_last", 32'(slst[0]), 32'd0);
      chk("midrst_load_ready", 32'(lr[0]), 32'd0);
      rst[0] = 1'b0; lv[0] = 1'b0;
      #1;
      chk("midrst_release_ready", 32'(lr[0]), 32'd1);
      step();
      for (int n = 0; n < 30; n++) begin
         chk("post_rst_no_step", 32'(sv[0]), 32'd0);
         chk("post_rst_idle", 32'(bz[0]), 32'd0);
         step();
      end

      // reset and a load handshake on the same edge: reset wins
      rst[1] = 1'b1; lv[1] = 1'b1; ld[1] = 8'h99;
      step();
      rst[1] = 1'b0; lv[1] = 1'b0;
      chk("rst_vs_load_busy", 32'(bz[1]), 32'd0);
      chk("rst_vs_load_word", 32'(li[1]), 32'd0);
      step();
      chk("rst_vs_load_stays_idle", 32'(bz[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
